measure_window_scheduler: RTL and testbench

Sequencing controller for the packet snooper. Drives the snooper's measure input for programmed windows separated by gaps. After each window it collects the three 64-bit count streams (cycle, packet, flit) and re-emits them as one 3-beat AXI-Stream result record for the host path.

---
 rtl/measure_window_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_measure_window_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/measure_window_scheduler.sv
// Window sequencer for the packet snooper: GAP -> MEASURE -> COLLECT -> EMIT per window,
// merging the three count streams into one 3-beat result record.
module measure_window_scheduler #(
  parameter int LEN_WIDTH      = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LEN_WIDTH-1:0] window_len,
  input  logic [LEN_WIDTH-1:0] gap_len,
  input  logic [CNT_WIDTH-1:0] num_windows,
  output logic                 measure,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] window_index,
  output logic                 timeout_err,
  input  logic [63:0]          cc_TDATA,
  input  logic                 cc_TVALID,
  output logic                 cc_TREADY,
  input  logic [63:0]          pc_TDATA,
  input  logic                 pc_TVALID,
  output logic                 pc_TREADY,
  input  logic [63:0]          fc_TDATA,
  input  logic                 fc_TVALID,
  output logic                 fc_TREADY,
  output logic [63:0]          res_TDATA,
  output logic [7:0]           res_TKEEP,
  output logic                 res_TVALID,
  input  logic                 res_TREADY,
  output logic                 res_TLAST
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, GAP, MEASURE, COLLECT, EMIT} state_t;

  state_t               state, state_d;
  logic [LEN_WIDTH-1:0] win_q, win_d, gap_q, gap_d, cnt, cnt_d;
  logic [CNT_WIDTH-1:0] num_q, num_d, idx_d;
  logic [TW-1:0]        tcnt, tcnt_d;
  logic [1:0]           beat, beat_d;
  logic [63:0]          cc_q, pc_q, fc_q, cc_d, pc_d, fc_d, rdata_d;
  logic                 abort_q, abort_d;
  logic                 measure_d, busy_d, terr_d, rv_d, rl_d;
  logic                 cc_rdy_d, pc_rdy_d, fc_rdy_d;

  always_comb begin
    state_d   = state;
    win_d     = win_q;
    gap_d     = gap_q;
    num_d     = num_q;
    cnt_d     = cnt;
    tcnt_d    = tcnt;
    beat_d    = beat;
    cc_d      = cc_q;
    pc_d      = pc_q;
    fc_d      = fc_q;
    idx_d     = window_index;
    abort_d   = abort_q;
    measure_d = measure;
    busy_d    = busy;
    terr_d    = timeout_err;
    rv_d      = res_TVALID;
    rl_d      = res_TLAST;
    rdata_d   = res_TDATA;
    cc_rdy_d  = cc_TREADY;
    pc_rdy_d  = pc_TREADY;
    fc_rdy_d  = fc_TREADY;

    unique case (state)
      IDLE: begin
        abort_d = 1'b0;
        // abort beats start when both arrive together
        if (start && !abort) begin
          win_d   = window_len;
          gap_d   = gap_len;
          num_d   = num_windows;
          terr_d  = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        abort_d = abort_q | abort;
        if (abort_d) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          abort_d = 1'b0;
        end else if (gap_q <= LEN_WIDTH'(1) || cnt == gap_q - 1'b1) begin
          state_d   = MEASURE;
          measure_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      MEASURE: begin
        abort_d = abort_q | abort;
        // abort only shortens the window so the snooper still reports
        if (abort_d || win_q <= LEN_WIDTH'(1) || cnt == win_q - 1'b1) begin
          state_d   = COLLECT;
          measure_d = 1'b0;
          tcnt_d    = '0;
          cc_d      = '0;
          pc_d      = '0;
          fc_d      = '0;
          cc_rdy_d  = 1'b1;
          pc_rdy_d  = 1'b1;
          fc_rdy_d  = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      COLLECT: begin
        abort_d = abort_q | abort;
        tcnt_d  = tcnt + 1'b1;
        if (cc_TVALID && cc_TREADY) begin cc_d = cc_TDATA; cc_rdy_d = 1'b0; end
        if (pc_TVALID && pc_TREADY) begin pc_d = pc_TDATA; pc_rdy_d = 1'b0; end
        if (fc_TVALID && fc_TREADY) begin fc_d = fc_TDATA; fc_rdy_d = 1'b0; end
        if (!(cc_rdy_d || pc_rdy_d || fc_rdy_d) || tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          if (cc_rdy_d || pc_rdy_d || fc_rdy_d) terr_d = 1'b1;
          state_d  = EMIT;
          cc_rdy_d = 1'b0;
          pc_rdy_d = 1'b0;
          fc_rdy_d = 1'b0;
          rv_d     = 1'b1;
          rl_d     = 1'b0;
          rdata_d  = cc_d;
          beat_d   = 2'd0;
        end
      end
      EMIT: begin
        abort_d = abort_q | abort;
        if (res_TREADY) begin
          if (beat == 2'd0) begin
            beat_d  = 2'd1;
            rdata_d = pc_q;
          end else if (beat == 2'd1) begin
            beat_d  = 2'd2;
            rdata_d = fc_q;
            rl_d    = 1'b1;
          end else begin
            rv_d   = 1'b0;
            rl_d   = 1'b0;
            beat_d = 2'd0;
            if (abort_d || (num_q != '0 && window_index == num_q - 1'b1)) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              abort_d = 1'b0;
            end else begin
              idx_d   = window_index + 1'b1;
              cnt_d   = '0;
              state_d = GAP;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      win_q        <= '0;
      gap_q        <= '0;
      num_q        <= '0;
      cnt          <= '0;
      tcnt         <= '0;
      beat         <= '0;
      cc_q         <= '0;
      pc_q         <= '0;
      fc_q         <= '0;
      abort_q      <= 1'b0;
      measure      <= 1'b0;
      busy         <= 1'b0;
      window_index <= '0;
      timeout_err  <= 1'b0;
      cc_TREADY    <= 1'b0;
      pc_TREADY    <= 1'b0;
      fc_TREADY    <= 1'b0;
      res_TDATA    <= '0;
      res_TKEEP    <= '0;
      res_TVALID   <= 1'b0;
      res_TLAST    <= 1'b0;
    end else begin
      state        <= state_d;
      win_q        <= win_d;
      gap_q        <= gap_d;
      num_q        <= num_d;
      cnt          <= cnt_d;
      tcnt         <= tcnt_d;
      beat         <= beat_d;
      cc_q         <= cc_d;
      pc_q         <= pc_d;
      fc_q         <= fc_d;
      abort_q      <= abort_d;
      measure      <= measure_d;
      busy         <= busy_d;
      window_index <= idx_d;
      timeout_err  <= terr_d;
      cc_TREADY    <= cc_rdy_d;
      pc_TREADY    <= pc_rdy_d;
      fc_TREADY    <= fc_rdy_d;
      res_TDATA    <= rdata_d;
      res_TKEEP    <= rv_d ? 8'hFF : 8'h00;
      res_TVALID   <= rv_d;
      res_TLAST    <= rl_d;
    end
  end
endmodule

// File: tb/tb_measure_window_scheduler.sv
// Scoreboard bench: a stub snooper answers each window, a monitor pops expected beats.
module tb_measure_window_scheduler;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [31:0] window_len = '0, gap_len = '0;
  logic [15:0] num_windows = '0;
  logic        measure, busy, timeout_err;
  logic [15:0] window_index;
  logic [63:0] cc_TDATA = '0, pc_TDATA = '0, fc_TDATA = '0;
  logic        cc_TVALID = 1'b0, pc_TVALID = 1'b0, fc_TVALID = 1'b0;
  logic        cc_TREADY, pc_TREADY, fc_TREADY;
  logic [63:0] res_TDATA;
  logic [7:0]  res_TKEEP;
  logic        res_TVALID, res_TLAST;
  logic        res_TREADY = 1'b1;

  measure_window_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .window_len(window_len), .gap_len(gap_len), .num_windows(num_windows),
    .measure(measure), .busy(busy), .window_index(window_index), .timeout_err(timeout_err),
    .cc_TDATA(cc_TDATA), .cc_TVALID(cc_TVALID), .cc_TREADY(cc_TREADY),
    .pc_TDATA(pc_TDATA), .pc_TVALID(pc_TVALID), .pc_TREADY(pc_TREADY),
    .fc_TDATA(fc_TDATA), .fc_TVALID(fc_TVALID), .fc_TREADY(fc_TREADY),
    .res_TDATA(res_TDATA), .res_TKEEP(res_TKEEP), .res_TVALID(res_TVALID),
    .res_TREADY(res_TREADY), .res_TLAST(res_TLAST)
  );

  always #5 clk = ~clk;

  typedef struct {logic [63:0] data; logic last;} beat_t;
  beat_t       q[$];
  beat_t       m_e;
  int          checks = 0, fails = 0;
  int          rdy_mode = 0;
  logic        fc_en = 1'b1;
  logic [63:0] pc_val = 64'd4, fc_val = 64'd12;
  int          mcnt = 0;
  logic        mprev = 1'b0;
  logic        pend = 1'b0, pl = 1'b0;
  logic [63:0] pd = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return measure;
      1:       return busy;
      default: return res_TVALID;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int sel, input logic val);
    int n = 0;
    do begin @(negedge clk); n++; end while (sig(sel) !== val && n < 2000);
    if (sig(sel) !== val) begin
      checks++; fails++;
      $display("FAIL %s: wait timed out, got %0b expected %0b", name, sig(sel), val);
    end
  endtask

  task automatic go(input logic [31:0] wl, input logic [31:0] gl, input logic [15:0] nw);
    window_len = wl; gap_len = gl; num_windows = nw; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic push_rec(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    q.push_back('{data: a, last: 1'b0});
    q.push_back('{data: b, last: 1'b0});
    q.push_back('{data: c, last: 1'b1});
  endtask

  task automatic drained(input string name);
    repeat (3) @(negedge clk);
    chk(name, 64'(q.size()), 64'd0);
  endtask

  // result ready pattern: 0 = always ready, 1 = toggle, other = stalled
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       res_TREADY = 1'b1;
      1:       res_TREADY = ~res_TREADY;
      default: res_TREADY = 1'b0;
    endcase
  end

  // stub snooper: counts measure-high cycles, presents all counts for one cycle after the window
  initial forever begin
    @(negedge clk);
    if (reset) begin
      mcnt = 0; mprev = 1'b0;
    end else begin
      if (measure) mcnt++;
      if (mprev && !measure) begin
        mprev = 1'b0;
        @(posedge clk); #1;
        cc_TDATA = 64'(mcnt); pc_TDATA = pc_val; fc_TDATA = fc_val;
        cc_TVALID = 1'b1; pc_TVALID = 1'b1; fc_TVALID = fc_en;
        @(posedge clk); #1;
        cc_TVALID = 1'b0; pc_TVALID = 1'b0; fc_TVALID = 1'b0; mcnt = 0;
      end else begin
        mprev = measure;
      end
    end
  end

  // monitor: hold-stability under backpressure and in-order beat comparison
  initial forever begin
    @(negedge clk);
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("hold_valid", 64'(res_TVALID), 64'd1);
        chk("hold_data", res_TDATA, pd);
        chk("hold_last", 64'(res_TLAST), 64'(pl));
      end
      if (res_TVALID && res_TREADY) begin
        if (q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_beat: got data %0d with empty scoreboard", res_TDATA);
        end else begin
          m_e = q.pop_front();
          chk("beat_data", res_TDATA, m_e.data);
          chk("beat_last", 64'(res_TLAST), 64'(m_e.last));
          chk("beat_keep", 64'(res_TKEEP), 64'hFF);
        end
      end
      pend = res_TVALID && !res_TREADY;
      pd   = res_TDATA;
      pl   = res_TLAST;
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_measure", 64'(measure), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_timeout", 64'(timeout_err), 64'd0);
    chk("rst_tvalid", 64'(res_TVALID), 64'd0);
    chk("rst_tlast", 64'(res_TLAST), 64'd0);
    chk("rst_tkeep", 64'(res_TKEEP), 64'd0);
    chk("rst_cc_rdy", 64'(cc_TREADY), 64'd0);
    chk("rst_pc_rdy", 64'(pc_TREADY), 64'd0);
    chk("rst_fc_rdy", 64'(fc_TREADY), 64'd0);
    chk("rst_index", 64'(window_index), 64'd0);
    chk("rst_tdata", res_TDATA, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);

    // single window: 3 gap cycles then exactly 10 measure cycles
    push_rec(64'd10, 64'd4, 64'd12);
    go(32'd10, 32'd3, 16'd1);
    n = 0;
    while (n < 200) begin @(negedge clk); if (measure) break; n++; end
    chk("single_gap_cycles", 64'(n), 64'd3);
    chk("single_busy", 64'(busy), 64'd1);
    n = 1;
    while (n < 200) begin @(negedge clk); if (!measure) break; n++; end
    chk("single_measure_cycles", 64'(n), 64'd10);
    wait_sig("single_idle", 1, 1'b0);
    drained("single_drain");
    chk("single_no_timeout", 64'(timeout_err), 64'd0);

    // start and abort together in IDLE: no run
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
    chk("start_abort_measure", 64'(measure), 64'd0);

    // three windows back to back, gap_len = 0
    pc_val = 64'd7; fc_val = 64'd9;
    for (int i = 0; i < 3; i++) push_rec(64'd5, 64'd7, 64'd9);
    go(32'd5, 32'd0, 16'd3);
    for (int i = 0; i < 3; i++) begin
      wait_sig("multi_meas_hi", 0, 1'b1);
      chk("multi_index", 64'(window_index), 64'(i));
      wait_sig("multi_meas_lo", 0, 1'b0);
    end
    wait_sig("multi_idle", 1, 1'b0);
    chk("multi_last_index", 64'(window_index), 64'd2);
    drained("multi_drain");

    // window_len = 0 behaves as a 1-cycle window
    push_rec(64'd1, 64'd7, 64'd9);
    go(32'd0, 32'd0, 16'd1);
    wait_sig("zero_len_idle", 1, 1'b0);
    drained("zero_len_drain");

    // backpressure: ready toggles every cycle
    rdy_mode = 1;
    push_rec(64'd3, 64'd7, 64'd9);
    push_rec(64'd3, 64'd7, 64'd9);
    go(32'd3, 32'd1, 16'd2);
    wait_sig("bp_idle", 1, 1'b0);
    drained("bp_drain");
    rdy_mode = 0;

    // timeout: flit count never arrives
    fc_en = 1'b0;
    push_rec(64'd4, 64'd7, 64'd0);
    go(32'd4, 32'd1, 16'd1);
    wait_sig("to_meas_hi", 0, 1'b1);
    wait_sig("to_meas_lo", 0, 1'b0);
    n = 0;
    while (!timeout_err && n < 200) begin n++; @(negedge clk); end
    chk("to_cycles", 64'(n), 64'd64);
    wait_sig("to_idle", 1, 1'b0);
    chk("to_sticky", 64'(timeout_err), 64'd1);
    drained("to_drain");
    fc_en = 1'b1;
    push_rec(64'd2, 64'd7, 64'd9);
    go(32'd2, 32'd0, 16'd1);
    @(negedge clk);
    chk("to_cleared", 64'(timeout_err), 64'd0);
    wait_sig("to2_idle", 1, 1'b0);
    drained("to2_drain");

    // abort on cycle 20 of a 100-cycle window, continuous mode
    push_rec(64'd20, 64'd7, 64'd9);
    go(32'd100, 32'd2, 16'd0);
    wait_sig("ab_meas_hi", 0, 1'b1);
    repeat (19) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    chk("ab_meas_still_hi", 64'(measure), 64'd1);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("ab_meas_dropped", 64'(measure), 64'd0);
    wait_sig("ab_idle", 1, 1'b0);
    chk("ab_index", 64'(window_index), 64'd0);
    n = 0;
    repeat (20) begin @(negedge clk); if (measure || busy) n++; end
    chk("ab_no_more_gap", 64'(n), 64'd0);
    drained("ab_drain");

    // reset while beat 2 is held
    rdy_mode = 2;
    push_rec(64'd3, 64'd7, 64'd9);
    go(32'd3, 32'd0, 16'd1);
    wait_sig("rst_emit_valid", 2, 1'b1);
    rdy_mode = 0;
    @(negedge clk);
    rdy_mode = 2;
    @(negedge clk);
    chk("rst_beat2_data", res_TDATA, 64'd7);
    chk("rst_beat2_last", 64'(res_TLAST), 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    q.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_tvalid", 64'(res_TVALID), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_measure", 64'(measure), 64'd0);
    rdy_mode = 0;
    push_rec(64'd6, 64'd7, 64'd9);
    go(32'd6, 32'd2, 16'd1);
    wait_sig("fresh_idle", 1, 1'b0);
    drained("fresh_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
